// File: rtl/mips_perf_counter_tx_if.sv
// UART transmit handshake between the perf counter bank (master) and the UART TX (slave).
interface mips_perf_counter_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_uart_tx_data;
    logic                 o_uart_tx_ready;
    logic                 i_uart_tx_done;

    modport master (
        output o_uart_tx_data,
        output o_uart_tx_ready,
        input  i_uart_tx_done
    );

    modport slave (
        input  o_uart_tx_data,
        input  o_uart_tx_ready,
        output i_uart_tx_done
    );
endinterface

// File: rtl/mips_perf_counter_tx.sv
// Multi-channel performance counter bank with coherent snapshot and byte-serial UART readout.
// Define PERF_CNT_HEADER_EN to prefix each readout with the bytes 0xA5 and CHANNELS.
module mips_perf_counter_tx #(
    parameter int NBITS     = 32,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       i_event,
    input  logic                      i_halt,
    input  logic                      i_clr,
    input  logic                      i_snap,
    output logic                      o_busy,
    output logic [CHANNELS*NBITS-1:0] o_count,
    output logic [CHANNELS-1:0]       o_overflow,
    mips_perf_counter_tx_if.master    uart
);

    localparam int PAYLOAD = CHANNELS * NBITS / DATA_BITS;
`ifdef PERF_CNT_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = PAYLOAD + HDR;
    localparam int IDX_W = $clog2(PAYLOAD + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    logic [NBITS-1:0]          count_q [CHANNELS];
    logic [CHANNELS*NBITS-1:0] shadow_q;
    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      advance_q;

    // Clear beats halt and events; a wrap from all-ones latches the sticky flag on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) count_q[k] <= '0;
            o_overflow <= '0;
        end else if (i_clr) begin
            for (int k = 0; k < CHANNELS; k++) count_q[k] <= '0;
            o_overflow <= '0;
        end else if (!i_halt) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (i_event[k]) begin
                    count_q[k] <= count_q[k] + NBITS'(1);
                    if (&count_q[k]) o_overflow[k] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_flat
        assign o_count[k*NBITS +: NBITS] = count_q[k];
    end

    function automatic logic [DATA_BITS-1:0] byte_at(
        input logic [CHANNELS*NBITS-1:0] vec,
        input logic [IDX_W-1:0]          idx
    );
        int payload_idx;
        payload_idx = int'(idx) - HDR;
`ifdef PERF_CNT_HEADER_EN
        if (idx == IDX_W'(0)) return DATA_BITS'(8'hA5);
        if (idx == IDX_W'(1)) return DATA_BITS'(CHANNELS);
`endif
        return DATA_BITS'(vec >> (payload_idx * DATA_BITS));
    endfunction

    // The first byte is taken from the live counters on the capture edge so ready follows snap
    // by one cycle; later bytes spend one extra WAIT cycle advancing the index before SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            idx_q                <= '0;
            advance_q            <= 1'b0;
            shadow_q             <= '0;
            uart.o_uart_tx_data  <= '0;
            uart.o_uart_tx_ready <= 1'b0;
            o_busy               <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_snap) begin
                        shadow_q             <= o_count;
                        idx_q                <= '0;
                        uart.o_uart_tx_data  <= byte_at(o_count, IDX_W'(0));
                        uart.o_uart_tx_ready <= 1'b1;
                        o_busy               <= 1'b1;
                        state_q              <= SEND;
                    end
                end
                SEND: begin
                    uart.o_uart_tx_ready <= 1'b0;
                    state_q              <= WAIT;
                end
                WAIT: begin
                    if (advance_q) begin
                        advance_q            <= 1'b0;
                        uart.o_uart_tx_data  <= byte_at(shadow_q, idx_q);
                        uart.o_uart_tx_ready <= 1'b1;
                        state_q              <= SEND;
                    end else if (uart.i_uart_tx_done) begin
                        if (idx_q == LAST_IDX) begin
                            o_busy  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            advance_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mips_perf_counter_tx.md
# mips_perf_counter_tx

Multi-channel performance counter bank with snapshot and byte-serialised UART readout. It generalises the single free-running MIPS clock-cycle counter kept in the top level: it counts cycles, instructions, stalls or halts per channel, supports freeze and clear, and streams a coherent snapshot through the UART transmitter's ready/done handshake. It sits beside the debug unit, driven by the same clock as the UART interfaces.

## Interface
- `NBITS`, 32, width of each counter; must be an integer multiple of `DATA_BITS`.
- `DATA_BITS`, 8, UART byte width.
- `CHANNELS`, 4, number of independent counters, legal range 1–16.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `i_event`  in  CHANNELS  per-channel increment strobe, sampled every cycle.
- `i_halt`  in  1  freezes all counters while high.
- `i_clr`  in  1  synchronous clear of counters and overflow flags.
- `i_snap`  in  1  requests a snapshot and readout.
- `i_uart_tx_done`  in  1  one-cycle pulse from the UART TX when the current byte has been sent.
- `o_uart_tx_data`  out  DATA_BITS  byte to transmit; held stable until the next byte is issued.
- `o_uart_tx_ready`  out  1  one-cycle start pulse to the UART TX.
- `o_busy`  out  1  high from snapshot capture until the last byte is done.
- `o_count`  out  CHANNELS*NBITS  live counters, flattened, channel 0 in the LSBs.
- `o_overflow`  out  CHANNELS  sticky per-channel wrap flags.

## Operation
- **Counters:**
  - Channel k increments by 1 on an edge where `i_event[k]=1` and `i_halt=0`.
  - At all-ones, the counter wraps to 0 and sets `o_overflow[k]`.
  - `i_clr` has priority over an event on the same edge.
  - Counting continues during readout.
- **Snapshot:**
  - On an edge with `i_snap=1` in IDLE, all live counters load into a shadow register with their pre-increment, pre-clear values.
  - `i_snap` while busy is ignored and is not queued.
- **Byte order:** channel 0 first; within a channel, the least-significant byte first.
  - Payload length P = CHANNELS*NBITS/DATA_BITS bytes.
- **FSM states:** IDLE, SEND, WAIT.
  - IDLE→SEND on `i_snap`: shadow loaded, byte index set to 0.
  - SEND (one cycle): `o_uart_tx_ready=1` and `o_uart_tx_data` set to the current byte; next state WAIT.
  - WAIT: when `i_uart_tx_done=1`, go to IDLE if this was the last byte; otherwise increment the index and go to SEND.
  - `i_uart_tx_done` in IDLE or SEND is ignored.
- **Busy:** `o_busy` is 1 in SEND and WAIT, and 0 in IDLE.

## Timing
- **Reset values:**
  - counters, shadow, `o_overflow`, `o_uart_tx_data`, `o_uart_tx_ready`, `o_busy`: all 0
  - state: IDLE
  - byte index: 0
- **Reset mid-readout:** aborts immediately; no further ready pulses are issued.
- **Latency:**
  - `i_snap` sampled at edge t → `o_uart_tx_ready` high in cycle t+1, for exactly one cycle.
  - `i_uart_tx_done` sampled at edge u → next ready pulse in cycle u+2 (WAIT→SEND, then SEND drives it).
- **Live counters:** `o_count` reflects increments one cycle after the sampling edge.
- **Overflow:** the flag sets on the same edge as the wrap.
- **Simultaneous events:**
  - `i_snap` + `i_clr`: snapshot holds the old values, live counters clear.
  - `i_halt` + `i_clr`: clear wins.
- **Byte index:** width $clog2(P+2).

## Configuration
- **`PERF_CNT_HEADER_EN` defined:** two header bytes precede the payload.
  - Header bytes: 0xA5, then CHANNELS[DATA_BITS-1:0].
  - Total transfer is P+2 bytes.
- **`PERF_CNT_HEADER_EN` undefined:** only the P payload bytes are sent.

## Test plan
- **Basic count and snapshot:** reset, then `i_event=4'b0001` for 10 cycles, then `i_snap` → `o_count[31:0]=10`. Bytes sent are 0x0A,0x00,0x00,0x00 followed by 12 zero bytes; `o_busy` falls after the 16th done.
- **Halt and clear:** events on all channels, `i_halt=1` for 5 of 20 cycles → each count is 15. `i_clr` together with `i_event=4'hF` → all counts 0 on the next cycle.
- **Wrap:** with NBITS=8 and CHANNELS=2, 256 events on channel 1 → count 0, `o_overflow=2'b10`. `i_clr` → `o_overflow=0`.
- **Snapshot coherence and ignored snap:** snap with channel 0 at 0x01020304 while events continue, plus a second `i_snap` mid-readout.
  - Bytes are 04,03,02,01; the extra snap is ignored.
  - The next ready pulse comes exactly 2 cycles after each done.
- **Reset mid-readout:** reset asserted after byte 2's ready pulse → `o_busy=0`, `o_uart_tx_ready` stays 0, counters are 0.
- **Header (`PERF_CNT_HEADER_EN` defined, CHANNELS=4):** first two bytes are 0xA5, 0x04; 18 ready pulses in total.
